// File: rtl/round_sat_pipe_if.sv
// round_sat_pipe_if: handshake bundle for the round/saturate stage.
//   in_valid/in_ready/in_data/in_mode : input sample channel
//   out_valid/out_ready/out_data/out_sat : result channel
// Modports: master (producer/consumer side, e.g. testbench), slave (the stage).
interface round_sat_pipe_if #(
  parameter int IN_W  = 18,
  parameter int OUT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_sat;

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/round_sat_pipe.sv
// round_sat_pipe: two-stage rounding and saturation of a signed fixed-point
// word (IN_W bits, IN_FRAC fraction) down to OUT_W bits with OUT_FRAC fraction.
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous active-high reset
//   bus      - round_sat_pipe_if.slave (input and result handshake channels)
//   cnt_clr  - synchronous clear of sat_cnt
//   sat_cnt  - count of delivered saturated results (saturates at all-ones)
// Build option: define SAT_CNT_EN to build the saturation counter; otherwise
// sat_cnt is tied to zero and cnt_clr is ignored.
module round_sat_pipe #(
  parameter int IN_W     = 18,
  parameter int IN_FRAC  = 16,
  parameter int OUT_W    = 8,
  parameter int OUT_FRAC = 7,
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  round_sat_pipe_if.slave      bus,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     sat_cnt
);

  localparam int D  = IN_FRAC - OUT_FRAC;
  localparam int KW = IN_W - D;
  localparam int SW = KW + 1;

  // Bits below the guard bit; empty when D = 1.
  localparam logic [IN_W-1:0] STICKY_MASK = (IN_W'(1) << (D - 1)) - IN_W'(1);
  localparam logic signed [SW-1:0] SAT_MAX =
    {{(SW - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {
    MODE_TRUNC   = 2'b00,
    MODE_HALF_UP = 2'b01,
    MODE_EVEN    = 2'b10,
    MODE_EVEN_B  = 2'b11
  } mode_e;

  mode_e            mode;
  logic [KW-1:0]    keep;
  logic             guard;
  logic             sticky;
  logic             inc;
  logic [SW-1:0]    sum;

  logic             s1_valid;
  logic signed [SW-1:0] s1_sum;
  logic             s1_adv;
  logic             s2_load;

  logic             sat_hi;
  logic             sat_lo;
  logic [OUT_W-1:0] sat_data;

  // Stage 1 rounding decision
  assign mode   = mode_e'(bus.in_mode);
  assign keep   = bus.in_data[IN_W-1:D];
  assign guard  = bus.in_data[D-1];
  assign sticky = |(bus.in_data & STICKY_MASK);

  always_comb begin
    inc = 1'b0;
    case (mode)
      MODE_TRUNC:   inc = 1'b0;
      MODE_HALF_UP: inc = guard;
      MODE_EVEN,
      MODE_EVEN_B:  inc = guard & (sticky | keep[0]);
      default:      inc = 1'b0;
    endcase
  end

  // One extra bit of headroom so keep + 1 never wraps.
  assign sum = {keep[KW-1], keep} + SW'(inc);

  // Handshake: each stage advances when its downstream slot is free or leaving.
  assign s2_load      = ~bus.out_valid | bus.out_ready;
  assign s1_adv       = ~s1_valid | s2_load;
  assign bus.in_ready = s1_adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
    end else if (s1_adv) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) s1_sum <= sum;
    end
  end

  // Stage 2 saturation
  always_comb begin
    sat_hi   = s1_sum > SAT_MAX;
    sat_lo   = s1_sum < SAT_MIN;
    sat_data = s1_sum[OUT_W-1:0];
    if (sat_hi)      sat_data = {1'b0, {(OUT_W - 1){1'b1}}};
    else if (sat_lo) sat_data = {1'b1, {(OUT_W - 1){1'b0}}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_sat   <= 1'b0;
    end else if (s2_load) begin
      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        bus.out_data <= sat_data;
        bus.out_sat  <= sat_hi | sat_lo;
      end
    end
  end

`ifdef SAT_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      sat_cnt <= '0;
    end else if (bus.out_valid && bus.out_ready && bus.out_sat && !(&sat_cnt)) begin
      sat_cnt <= sat_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign sat_cnt        = '0;
`endif

endmodule

// File: doc/round_sat_pipe.md
# round_sat_pipe

Parametrised, pipelined rounding and saturation stage that reduces a signed fixed-point CORDIC datapath word to a narrower signed fixed-point output. It generalises the fixed 18-to-8-bit round-off stage: widths and fraction positions are parameters, the rounding mode is selectable per sample, and a valid/ready handshake carries each result with a saturation flag. It sits between the CORDIC iteration core and the output register or bus.

## Interface
- IN_W, 18, input word width (signed, two's complement)
- IN_FRAC, 16, input fractional bits
- OUT_W, 8, output word width (signed)
- OUT_FRAC, 7, output fractional bits; D = IN_FRAC-OUT_FRAC, D >= 1, OUT_W <= IN_W-D+1
- CNT_W, 16, saturation event counter width

- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input sample valid
- in_ready  out  1  stage accepts input this cycle
- in_data  in  IN_W  input sample
- in_mode  in  2  rounding mode for this sample: 00 truncate (floor), 01 round-half-up (toward +inf), 10 and 11 round-half-even
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  OUT_W  rounded, saturated result
- out_sat  out  1  result was clamped
- sat_cnt  out  CNT_W  count of saturated results delivered
- cnt_clr  in  1  synchronous clear of sat_cnt

## Operation
- Stage 1 (on input handshake): keep = in_data >>> D (arithmetic, IN_W-D bits); guard = in_data[D-1]; sticky = OR of in_data[D-2:0] (0 when D=1); lsb = keep[0].
- Increment: mode 00 → 0; mode 01 → guard; mode 10/11 → guard & (sticky | lsb).
- Register sum = sign-extended keep + inc at IN_W-D+1 bits; no wrap possible.
- Stage 2: if sum > 2^(OUT_W-1)-1 → out_data = 0111…1, out_sat=1; if sum < -2^(OUT_W-1) → out_data = 1000…0, out_sat=1; else out_data = sum[OUT_W-1:0], out_sat=0. With defaults, a value rounding to +1.0 yields 8'h7F.
- Handshake: s2_load = ~out_valid | out_ready; s1_adv = ~s1_valid | s2_load; in_ready = s1_adv. Transfer only when valid & ready both high.
- out_data/out_sat held stable while out_valid & ~out_ready.
- sat_cnt increments on each output handshake with out_sat=1; sticks at all-ones. cnt_clr forces 0 next cycle and wins over a simultaneous increment.

## Timing
- Latency: 2 cycles input handshake → out_valid (stage 1 register, stage 2 register).
- Throughput: one sample per cycle while out_ready high; no bubbles.
- Backpressure: with out_ready low, one sample held in each stage, then in_ready drops; in_ready rises in the same cycle out_ready rises (combinational path).
- Reset: out_valid=0, internal stage valids=0, out_data=0, out_sat=0, sat_cnt=0, in_ready=1 in the first cycle after reset. Reset mid-stream discards both in-flight samples; no output is produced for them.
- in_mode is sampled with in_data; changing mode never affects in-flight samples.

## Configuration
- SAT_CNT_EN: defined → sat_cnt counter and cnt_clr logic are built as above. Undefined → no counter register; sat_cnt tied to 0; cnt_clr ignored; out_sat still produced.

## Test plan
- Defaults, in_data=18'h00300: mode 00 → 8'h01; mode 01 → 8'h02; mode 10 → 8'h02 (tie, odd lsb rounds up); out_sat=0.
- in_data=18'h00100: mode 01 → 8'h01; mode 10 → 8'h00 (tie to even); mode 00 → 8'h00.
- in_data=18'h3FFFF: mode 00 → 8'hFF; mode 01 → 8'h00. in_data=18'h0FFFF, mode 01 → 8'h7F, out_sat=1. in_data=18'h20000 → 8'h80, out_sat=1.
- Stream 8 samples back-to-back with out_ready=1 → 8 results in order, first 2 cycles after first accept, one per cycle.
- Hold out_ready=0 for 5 cycles mid-stream → in_ready low after 2 accepts, out_data stable, no loss or duplication after release.
- With SAT_CNT_EN: 3 saturating results delivered → sat_cnt=3; cnt_clr asserted on a saturating handshake → sat_cnt=0; assert rst with 2 samples in flight → out_valid=0, sat_cnt=0, no stale outputs.
